// File: rtl/gb_interrupt_ctrl.sv
// gb_interrupt_ctrl: IF/IE interrupt registers with source edge detect, priority select and CPU acknowledge
module gb_interrupt_ctrl #(
  parameter int          NUM_SRC = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [15:0]        addr_i,
  input  logic [7:0]         wdata_i,
  input  logic               wr_en_i,
  input  logic               clear_interrupt_flag,
  output logic [7:0]         rdata_o,
  output logic               rsel_o,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  output logic               irq_pending_o,
  output logic [15:0]        irq_vector_o
);
  logic [NUM_SRC-1:0] if_q, src_prev, pend, ack_mask, set_mask, if_base, clr;
  logic [7:0]         ie_q;
  logic               if_sel, ie_sel;
  assign if_sel        = addr_i == IF_ADDR;
  assign ie_sel        = addr_i == IE_ADDR;
  assign pend          = if_q & ie_q[NUM_SRC-1:0];
  assign ack_mask      = pend & -pend;
  assign set_mask      = irq_src_i & ~src_prev;
  assign if_base       = (wr_en_i && if_sel) ? wdata_i[NUM_SRC-1:0] : if_q;
  assign clr           = clear_interrupt_flag ? ack_mask : '0;
  assign reg_IF        = {{(8-NUM_SRC){1'b0}}, if_q};
  assign reg_IE        = ie_q;
  assign irq_pending_o = |pend;
  assign rsel_o        = if_sel | ie_sel;
  assign rdata_o       = if_sel ? {{(8-NUM_SRC){1'b1}}, if_q} : ie_sel ? ie_q : 8'h00;
  // ISR vector of the one-hot winner: 0x40 + 8*n
  always_comb begin
    irq_vector_o = 16'h0000;
    for (int i = 0; i < NUM_SRC; i++)
      if (ack_mask[i]) irq_vector_o = 16'h0040 + 16'(8 * i);
  end
  // State update: a new edge beats an acknowledge, which beats a bus write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_q     <= '0;
      ie_q     <= 8'h00;
      src_prev <= '0;
    end else begin
      src_prev <= irq_src_i;
      if_q     <= (if_base & ~clr) | set_mask;
      if (wr_en_i && ie_sel) ie_q <= wdata_i;
    end
  end
endmodule
